// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, field positions
// and the PC step.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned FUNC_MSB   = 5;
  localparam int unsigned FUNC_LSB   = 0;

  localparam logic [31:0] PC_INC        = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_reg.sv
// Program counter: async reset to RESET_PC, word-aligned redirect load, +4 step.
module pc_reg
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  logic        inc,
  output logic [31:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_addr & PC_ALIGN_MASK;
    end else if (inc) begin
      pc <= pc + PC_INC;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding memory read, holds the word for the decoder,
// and drops in-flight responses after a redirect.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_word,
  output logic [5:0]  inst,
  output logic [5:0]  func,
  output logic [31:0] pc_out,
  input  logic        redirect,
  input  logic [31:0] redirect_target
);

  state_t      state, state_nx;
  logic [31:0] pc;
  logic [31:0] fetch_addr;
  logic        pc_load;
  logic        pc_inc;
  logic        capture;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pc_load),
    .load_addr (redirect_target),
    .inc       (pc_inc),
    .pc        (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_START;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    capture    = 1'b0;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    case (state)
      S_START: begin
        pc_load  = redirect;
        state_nx = S_REQ;
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_load  = 1'b1;
          state_nx = imem_ack ? S_REQ : S_DROP;
        end else if (imem_ack) begin
          capture  = 1'b1;
          pc_inc   = 1'b1;
          state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        inst_valid = 1'b1;
        if (redirect) begin
          pc_load  = 1'b1;
          state_nx = S_REQ;
        end else if (inst_ready) begin
          state_nx = S_REQ;
        end
      end
      S_DROP: begin
        imem_req = 1'b1;
        pc_load  = redirect;
        if (imem_ack) begin
          state_nx = S_REQ;
        end
      end
      default: state_nx = S_START;
    endcase
  end

  // pc already holds the redirect target in DROP, so the outstanding request
  // keeps the address latched while it was issued from REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr <= '0;
    end else if (state == S_REQ) begin
      fetch_addr <= pc;
    end
  end

  assign imem_addr = (state == S_DROP) ? fetch_addr : pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_word <= '0;
      pc_out    <= '0;
    end else if (capture) begin
      inst_word <= imem_rdata;
      pc_out    <= pc;
    end
  end

  assign inst = inst_word[OPCODE_MSB:OPCODE_LSB];
  assign func = inst_word[FUNC_MSB:FUNC_LSB];

endmodule
